bc_msg_arbiter: RTL and testbench

- Shares the single broadcast-message bus between CORE_COUNT core wrappers.
- Each wrapper's registered bc_msg_out channel (valid/ready) is arbitrated round-robin.
- The winning message is registered and fanned out to every wrapper's bc_msg_in. That input is valid-only and has no backpressure.
- Messages from cores held in core_reset are flushed and counted, never broadcast. Per-core statistics are readable through a select/count port.

---
 rtl/bc_msg_arbiter.sv | 149 ++++++++++++++
 tb/tb_bc_msg_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_msg_arbiter.sv
// Round-robin arbiter for the shared broadcast-message bus. Grants one eligible core per
// cycle, registers the winning message for fan-out, flushes messages from cores held in
// reset, and keeps saturating per-core sent/flush statistics.
module bc_msg_arbiter #(
  parameter int unsigned CORE_COUNT    = 8,
  parameter int unsigned CORE_ID_WIDTH = 3,
  parameter int unsigned MSG_WIDTH     = 47,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
  input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
  input  logic [CORE_COUNT-1:0]           core_reset,
  input  logic                            arb_enable,
  output logic [MSG_WIDTH-1:0]            m_bc_msg,
  output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
  output logic                            m_bc_msg_valid,
  input  logic [CORE_ID_WIDTH-1:0]        stat_sel,
  output logic [CNT_WIDTH-1:0]            stat_sent_cnt,
  output logic [CNT_WIDTH-1:0]            stat_flush_cnt
);

  // Elaboration-time parameter sanity checks.
  if (CORE_ID_WIDTH != $clog2(CORE_COUNT)) begin : gen_bad_id_width
    $error("bc_msg_arbiter: CORE_ID_WIDTH must equal $clog2(CORE_COUNT)");
  end
  if (CORE_COUNT < 2 || CORE_COUNT > 16) begin : gen_bad_core_count
    $error("bc_msg_arbiter: CORE_COUNT must be in 2..16");
  end

  logic [MSG_WIDTH-1:0]     msg_arr [CORE_COUNT];
  logic [CORE_COUNT-1:0]    elig;
  logic [CORE_COUNT-1:0]    flush;
  logic [CORE_COUNT-1:0]    grant_oh;
  logic                     grant_vld;
  logic [CORE_ID_WIDTH-1:0] grant_idx;

  logic [CORE_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [MSG_WIDTH-1:0]     msg_q, msg_d;
  logic [CORE_ID_WIDTH-1:0] src_q, src_d;
  logic                     vld_q, vld_d;
  logic [CNT_WIDTH-1:0]     sent_q [CORE_COUNT];
  logic [CNT_WIDTH-1:0]     sent_d [CORE_COUNT];
  logic [CNT_WIDTH-1:0]     flush_q [CORE_COUNT];
  logic [CNT_WIDTH-1:0]     flush_d [CORE_COUNT];
  logic [CNT_WIDTH-1:0]     stat_sent_q, stat_sent_d;
  logic [CNT_WIDTH-1:0]     stat_flush_q, stat_flush_d;

  for (genvar i = 0; i < CORE_COUNT; i++) begin : gen_unpack
    assign msg_arr[i] = s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH];
  end

  assign elig  = s_bc_msg_valid & ~core_reset & {CORE_COUNT{arb_enable}};
  assign flush = s_bc_msg_valid & core_reset;

  // Round-robin search starting at the priority pointer, wrapping at CORE_COUNT.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= CORE_COUNT) begin
        idx = idx - CORE_COUNT;
      end
      if (!grant_vld && elig[idx[CORE_ID_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[CORE_ID_WIDTH-1:0];
      end
    end
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Readies are forced low during reset so nothing is accepted on the reset edge.
  always_comb begin
    s_bc_msg_ready = '0;
    if (rst_n) begin
      s_bc_msg_ready = grant_oh | flush;
    end
  end

  // Output register, pointer and statistics next-state.
  always_comb begin
    msg_d        = msg_q;
    src_d        = src_q;
    vld_d        = 1'b0;
    ptr_d        = ptr_q;
    stat_sent_d  = '0;
    stat_flush_d = '0;
    if (grant_vld) begin
      msg_d = msg_arr[grant_idx];
      src_d = grant_idx;
      vld_d = 1'b1;
      // Explicit compare so non-power-of-2 core counts wrap correctly.
      ptr_d = (grant_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0
                                                             : grant_idx + CORE_ID_WIDTH'(1);
    end
    for (int unsigned i = 0; i < CORE_COUNT; i++) begin
      sent_d[i]  = sent_q[i];
      flush_d[i] = flush_q[i];
      if (grant_oh[i] && (sent_q[i] != '1)) begin
        sent_d[i] = sent_q[i] + CNT_WIDTH'(1);
      end
      if (flush[i] && (flush_q[i] != '1)) begin
        flush_d[i] = flush_q[i] + CNT_WIDTH'(1);
      end
    end
    if (32'(stat_sel) < CORE_COUNT) begin
      stat_sent_d  = sent_q[stat_sel];
      stat_flush_d = flush_q[stat_sel];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      msg_q        <= '0;
      src_q        <= '0;
      vld_q        <= 1'b0;
      sent_q       <= '{default: '0};
      flush_q      <= '{default: '0};
      stat_sent_q  <= '0;
      stat_flush_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      msg_q        <= msg_d;
      src_q        <= src_d;
      vld_q        <= vld_d;
      sent_q       <= sent_d;
      flush_q      <= flush_d;
      stat_sent_q  <= stat_sent_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign m_bc_msg       = msg_q;
  assign m_bc_msg_src   = src_q;
  assign m_bc_msg_valid = vld_q;
  assign stat_sent_cnt  = stat_sent_q;
  assign stat_flush_cnt = stat_flush_q;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed testbench for bc_msg_arbiter: an 8-core instance, a 5-core instance for
// non-power-of-2 wrap, and an 8-core instance with 4-bit counters for saturation.
module tb_bc_msg_arbiter;

  localparam int W = 47;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-core instance
  logic [8*W-1:0] a_msg;
  logic [7:0]     a_vld, a_rdy, a_crst;
  logic           a_en, a_mv;
  logic [W-1:0]   a_m;
  logic [2:0]     a_src, a_sel;
  logic [31:0]    a_sent, a_fl;

  // 5-core instance
  logic [5*W-1:0] b_msg;
  logic [4:0]     b_vld, b_rdy, b_crst;
  logic           b_en, b_mv;
  logic [W-1:0]   b_m;
  logic [2:0]     b_src, b_sel;
  logic [31:0]    b_sent, b_fl;

  // 8-core instance with 4-bit counters
  logic [8*W-1:0] c_msg;
  logic [7:0]     c_vld, c_rdy, c_crst;
  logic           c_en, c_mv;
  logic [W-1:0]   c_m;
  logic [2:0]     c_src, c_sel;
  logic [3:0]     c_sent, c_fl;

  bc_msg_arbiter #(.CORE_COUNT(8), .CORE_ID_WIDTH(3), .MSG_WIDTH(W), .CNT_WIDTH(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_bc_msg(a_msg), .s_bc_msg_valid(a_vld),
    .s_bc_msg_ready(a_rdy), .core_reset(a_crst), .arb_enable(a_en), .m_bc_msg(a_m),
    .m_bc_msg_src(a_src), .m_bc_msg_valid(a_mv), .stat_sel(a_sel),
    .stat_sent_cnt(a_sent), .stat_flush_cnt(a_fl)
  );

  bc_msg_arbiter #(.CORE_COUNT(5), .CORE_ID_WIDTH(3), .MSG_WIDTH(W), .CNT_WIDTH(32)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .s_bc_msg(b_msg), .s_bc_msg_valid(b_vld),
    .s_bc_msg_ready(b_rdy), .core_reset(b_crst), .arb_enable(b_en), .m_bc_msg(b_m),
    .m_bc_msg_src(b_src), .m_bc_msg_valid(b_mv), .stat_sel(b_sel),
    .stat_sent_cnt(b_sent), .stat_flush_cnt(b_fl)
  );

  bc_msg_arbiter #(.CORE_COUNT(8), .CORE_ID_WIDTH(3), .MSG_WIDTH(W), .CNT_WIDTH(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .s_bc_msg(c_msg), .s_bc_msg_valid(c_vld),
    .s_bc_msg_ready(c_rdy), .core_reset(c_crst), .arb_enable(c_en), .m_bc_msg(c_m),
    .m_bc_msg_src(c_src), .m_bc_msg_valid(c_mv), .stat_sel(c_sel),
    .stat_sent_cnt(c_sent), .stat_flush_cnt(c_fl)
  );

  // Distinct per-core payload: {address, strobes, data}.
  function automatic logic [W-1:0] msg_pat(input int i);
    return {11'(i + 1), 4'hF, 32'hA500_0000 + 32'(i)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    a_vld = '0; a_crst = '0; b_vld = '0; b_crst = '0; c_vld = '0; c_crst = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; a_vld = '1; a_en = 1'b1; a_sel = 3'd0;
    #1;
    n_checks++;
    if (a_rdy !== 8'h00) begin
      n_fail++; $display("FAIL reset_ready: got %h want 00", a_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (a_mv !== 1'b0) begin
      n_fail++; $display("FAIL reset_mvalid: got %b want 0", a_mv);
    end
    n_checks++;
    if (a_sent !== 32'd0 || a_fl !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats: got sent=%0d flush=%0d want 0/0", a_sent, a_fl);
    end
    n_checks++;
    if (a_rdy !== 8'h00) begin
      n_fail++; $display("FAIL reset_ready_hold: got %h want 00", a_rdy);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (a_rdy !== 8'h01) begin
      n_fail++; $display("FAIL reset_first_grant: got %h want 01", a_rdy);
    end
    a_vld = '0;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if (a_mv !== 1'b1 || a_src !== 3'((c - 1) % 8) || a_m !== msg_pat((c - 1) % 8)) begin
          n_fail++;
          $display("FAIL rr_out[%0d]: got v=%b src=%0d msg=%h want v=1 src=%0d msg=%h",
                   c - 1, a_mv, a_src, a_m, (c - 1) % 8, msg_pat((c - 1) % 8));
        end
      end
      if (c < 16) begin
        a_vld = '1;
        #1;
        n_checks++;
        if (a_rdy !== 8'(1 << (c % 8))) begin
          n_fail++; $display("FAIL rr_ready[%0d]: got %h want %h", c, a_rdy, 8'(1 << (c % 8)));
        end
      end else begin
        a_vld = '0;
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if (a_mv !== 1'b1 || a_src !== 3'd3 || a_m !== msg_pat(3)) begin
          n_fail++;
          $display("FAIL flush_out[%0d]: got v=%b src=%0d want v=1 src=3", c - 1, a_mv, a_src);
        end
      end
      if (c < 10) begin
        a_crst = 8'h04; a_vld = 8'h0C;
        #1;
        n_checks++;
        if (a_rdy !== 8'h0C) begin
          n_fail++; $display("FAIL flush_ready[%0d]: got %h want 0c", c, a_rdy);
        end
      end else begin
        a_vld = '0; a_crst = '0; a_sel = 3'd2;
      end
    end
    @(negedge clk);
    n_checks++;
    if (a_fl !== 32'd10) begin
      n_fail++; $display("FAIL flush_cnt_core2: got %0d want 10", a_fl);
    end
    n_checks++;
    if (a_sent !== 32'd0) begin
      n_fail++; $display("FAIL sent_cnt_core2: got %0d want 0", a_sent);
    end
    a_sel = 3'd3;
    @(negedge clk);
    n_checks++;
    if (a_sent !== 32'd10 || a_fl !== 32'd0) begin
      n_fail++; $display("FAIL stats_core3: got sent=%0d flush=%0d want 10/0", a_sent, a_fl);
    end
  endtask

  // Pointer is 4 on entry (last grant went to core 3).
  task automatic test_midstream();
    @(negedge clk);
    a_vld = 8'h20;
    #1;
    n_checks++;
    if (a_rdy !== 8'h20) begin
      n_fail++; $display("FAIL mid_grant5: got %h want 20", a_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (a_mv !== 1'b1 || a_src !== 3'd5 || a_m !== msg_pat(5)) begin
      n_fail++; $display("FAIL mid_accepted_bcast: got v=%b src=%0d want v=1 src=5", a_mv, a_src);
    end
    a_crst = 8'h20;
    #1;
    n_checks++;
    if (a_rdy !== 8'h20) begin
      n_fail++; $display("FAIL mid_flush_ready: got %h want 20", a_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (a_mv !== 1'b0) begin
      n_fail++; $display("FAIL mid_flushed_not_bcast: got v=%b want 0", a_mv);
    end
    a_vld = '0; a_crst = '0; a_sel = 3'd5;
    @(negedge clk);
    n_checks++;
    if (a_sent !== 32'd1 || a_fl !== 32'd1) begin
      n_fail++; $display("FAIL mid_stats_core5: got sent=%0d flush=%0d want 1/1", a_sent, a_fl);
    end
  endtask

  // Pointer is 6 on entry; it must survive three disabled cycles.
  task automatic test_arb_disable();
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if (a_mv !== 1'b0) begin
          n_fail++; $display("FAIL dis_no_bcast[%0d]: got v=%b want 0", c - 1, a_mv);
        end
      end
      if (c < 3) begin
        a_en = 1'b0; a_vld = '1; a_crst = 8'h02;
        #1;
        n_checks++;
        if (a_rdy !== 8'h02) begin
          n_fail++; $display("FAIL dis_ready[%0d]: got %h want 02", c, a_rdy);
        end
      end
    end
    a_en = 1'b1; a_crst = '0;
    #1;
    n_checks++;
    if (a_rdy !== 8'h40) begin
      n_fail++; $display("FAIL dis_ptr_hold: got %h want 40", a_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (a_mv !== 1'b1 || a_src !== 3'd6) begin
      n_fail++; $display("FAIL dis_resume_bcast: got v=%b src=%0d want v=1 src=6", a_mv, a_src);
    end
    a_vld = '0;
  endtask

  // 5 cores, only 1 and 4 valid: grants alternate 1,4,1,4,... across the 4->0 wrap.
  task automatic test_wrap_npot();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c > 0) begin
        n_checks++;
        if (b_mv !== 1'b1 || b_src !== (((c - 1) % 2 == 0) ? 3'd1 : 3'd4)) begin
          n_fail++;
          $display("FAIL wrap_src[%0d]: got v=%b src=%0d want v=1 src=%0d", c - 1, b_mv, b_src,
                   ((c - 1) % 2 == 0) ? 1 : 4);
        end
      end
      if (c < 6) begin
        b_vld = 5'b10010;
        #1;
        n_checks++;
        if (b_rdy !== ((c % 2 == 0) ? 5'b00010 : 5'b10000)) begin
          n_fail++;
          $display("FAIL wrap_ready[%0d]: got %b want %b", c, b_rdy,
                   (c % 2 == 0) ? 5'b00010 : 5'b10000);
        end
      end else begin
        b_vld = '0; b_sel = 3'd1;
      end
    end
    @(negedge clk);
    n_checks++;
    if (b_sent !== 32'd3) begin
      n_fail++; $display("FAIL wrap_sent_core1: got %0d want 3", b_sent);
    end
    b_sel = 3'd6;
    @(negedge clk);
    n_checks++;
    if (b_sent !== 32'd0 || b_fl !== 32'd0) begin
      n_fail++; $display("FAIL stat_out_of_range: got sent=%0d flush=%0d want 0/0", b_sent, b_fl);
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c < 20) begin
        c_vld = 8'h01;
        #1;
        if (c == 0 || c == 19) begin
          n_checks++;
          if (c_rdy !== 8'h01) begin
            n_fail++; $display("FAIL sat_ready[%0d]: got %h want 01", c, c_rdy);
          end
        end
      end else begin
        c_vld = '0; c_sel = 3'd0;
      end
    end
    @(negedge clk);
    n_checks++;
    if (c_sent !== 4'hF) begin
      n_fail++; $display("FAIL sat_sent_cnt: got %0d want 15", c_sent);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_vld = '0; a_crst = '0; a_en = 1'b1; a_sel = '0;
    b_vld = '0; b_crst = '0; b_en = 1'b1; b_sel = '0;
    c_vld = '0; c_crst = '0; c_en = 1'b1; c_sel = '0;
    for (int i = 0; i < 8; i++) begin
      a_msg[i*W +: W] = msg_pat(i);
      c_msg[i*W +: W] = msg_pat(i);
    end
    for (int i = 0; i < 5; i++) begin
      b_msg[i*W +: W] = msg_pat(i);
    end
    test_reset();
    test_round_robin();
    test_flush();
    test_midstream();
    test_arb_disable();
    test_wrap_npot();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
